// File: rtl/router_out_arbiter_if.sv
// rtl/router_out_arbiter_if.sv - FIFO-side and link-side signals of one router output port
interface router_out_arbiter_if #(
  parameter int WIDTH  = 16,
  parameter int NPORTS = 4
) ();
  logic [NPORTS-1:0]       empty_i;
  logic [NPORTS*WIDTH-1:0] data_i;
  logic [NPORTS-1:0]       rd_o;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    input  empty_i, data_i, out_ready,
    output rd_o, out_data, out_valid
  );

  modport slave (
    output empty_i, data_i, out_ready,
    input  rd_o, out_data, out_valid
  );
endinterface

// File: rtl/router_out_arbiter.sv
// rtl/router_out_arbiter.sv - wormhole output arbiter: round-robin header grant, owner holds link until last flit
module router_out_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NPORTS  = 4,
  parameter int PORT_ID = 0,
  parameter int DESTW   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  router_out_arbiter_if.master bus,
  output logic [NPORTS-1:0]    grant_o,
  output logic                 busy
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  localparam logic [DESTW-1:0] MY_DEST   = DESTW'(PORT_ID);
  localparam logic [PW-1:0]    LAST_PORT = PW'(NPORTS - 1);

  logic [0:0]        state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     owner;
  logic [PW-1:0]     sel_idx;
  logic              sel_found;
  logic              load_en;
  logic              capture;
  logic [NPORTS-1:0] req;
  logic [NPORTS-1:0] rd_q;
  logic [NPORTS-1:0] sel_onehot;
  logic [WIDTH-1:0]  sel_flit;
  logic [WIDTH-1:0]  data_q;
  logic              valid_q;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    return PW'((int'(base) + off) % NPORTS);
  endfunction

  assign load_en = ~valid_q | bus.out_ready;

  // A port popped last cycle is masked: its head may not reflect the pop yet.
  always_comb begin
    req = '0;
    for (int p = 0; p < NPORTS; p++) begin
      req[p] = ~bus.empty_i[p] & ~rd_q[p] &
               (bus.data_i[p*WIDTH + WIDTH-2 -: DESTW] == MY_DEST);
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = owner;
    if (state == IDLE) begin
      for (int i = 1; i <= NPORTS; i++) begin
        if (!sel_found && req[wrap_add(rr_ptr, i)]) begin
          sel_found = 1'b1;
          sel_idx   = wrap_add(rr_ptr, i);
        end
      end
    end else begin
      sel_found = ~bus.empty_i[owner];
    end
  end

  always_comb begin
    sel_flit = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (sel_idx == PW'(p)) sel_flit = bus.data_i[p*WIDTH +: WIDTH];
    end
  end

  assign capture    = sel_found & load_en;
  assign sel_onehot = capture ? (NPORTS'(1) << sel_idx) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rd_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      grant_o <= '0;
      rr_ptr  <= LAST_PORT;
      owner   <= '0;
    end else begin
      rd_q <= sel_onehot;
      if (capture) begin
        data_q  <= sel_flit;
        valid_q <= 1'b1;
        grant_o <= sel_onehot;
        if (sel_flit[WIDTH-1]) begin
          state  <= IDLE;
          rr_ptr <= sel_idx;
        end else begin
          state <= LOCKED;
          owner <= sel_idx;
        end
      end else begin
        if (bus.out_ready) valid_q <= 1'b0;
        // Grant lingers one cycle after a packet's last flit, then drops.
        if (state == IDLE) grant_o <= '0;
      end
    end
  end

  assign busy          = (state == LOCKED);
  assign bus.rd_o      = rd_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_router_out_arbiter.sv
// tb/tb_router_out_arbiter.sv - directed bench for router_out_arbiter (PORT_ID=1)
module tb_router_out_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] grant_o;
  logic       busy;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [15:0] q[4][$];

  router_out_arbiter_if #(.WIDTH(16), .NPORTS(4)) bus ();

  router_out_arbiter #(.WIDTH(16), .NPORTS(4), .PORT_ID(1), .DESTW(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.master),
    .grant_o (grant_o),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    for (int p = 0; p < 4; p++) begin
      bus.empty_i[p] = (q[p].size() == 0);
      bus.data_i[p*16 +: 16] = (q[p].size() == 0) ? 16'h0000 : q[p][0];
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      if (bus.rd_o[p] && q[p].size() > 0) void'(q[p].pop_front());
    end
    refresh();
  endtask

  task automatic expect_out(input string tag, input logic [3:0] rd, input logic [15:0] data,
                            input logic valid, input logic [3:0] grant, input logic bsy);
    check({tag, ".rd_o"},      bus.rd_o,      rd);
    check({tag, ".out_data"},  bus.out_data,  data);
    check({tag, ".out_valid"}, bus.out_valid, valid);
    check({tag, ".grant_o"},   grant_o,       grant);
    check({tag, ".busy"},      busy,          bsy);
  endtask

  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b1;
    refresh();
    step();
    step();
    expect_out("reset", 4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0);
    reset = 1'b0;

    // single-flit packet from port 2
    q[2].push_back(16'hA123);
    refresh();
    step(); expect_out("single.cap",  4'b0100, 16'hA123, 1'b1, 4'b0100, 1'b0);
    step(); expect_out("single.idle", 4'b0000, 16'hA123, 1'b0, 4'b0000, 1'b0);

    // rr_ptr=2, so port 3 wins over port 1
    q[3].push_back(16'hA000);
    q[1].push_back(16'hA000);
    refresh();
    step(); expect_out("rr.p3", 4'b1000, 16'hA000, 1'b1, 4'b1000, 1'b0);
    step(); expect_out("rr.p1", 4'b0010, 16'hA000, 1'b1, 4'b0010, 1'b0);
    step();

    // from reset, ports 0 and 3 alternate
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      q[0].push_back(16'hA000);
      q[3].push_back(16'hA000);
    end
    refresh();
    step(); check("alt.g0", grant_o, 4'b0001);
    step(); check("alt.g1", grant_o, 4'b1000);
    step(); check("alt.g2", grant_o, 4'b0001);
    step(); check("alt.g3", grant_o, 4'b1000);
    step(); expect_out("alt.idle", 4'b0000, 16'hA000, 1'b0, 4'b0000, 1'b0);

    // header for another output on port 0 is ignored
    q[0].push_back(16'h8000);
    q[3].push_back(16'hA000);
    refresh();
    step(); expect_out("dest.p3", 4'b1000, 16'hA000, 1'b1, 4'b1000, 1'b0);
    step(); expect_out("dest.idle", 4'b0000, 16'hA000, 1'b0, 4'b0000, 1'b0);
    check("dest.p0_kept", q[0].size(), 1);
    q[0].delete();
    refresh();

    // three-flit packet on port 1, port 0 waits
    q[1].push_back(16'h2001);
    q[1].push_back(16'h0055);
    q[1].push_back(16'h8077);
    refresh();
    step(); expect_out("pkt.f0", 4'b0010, 16'h2001, 1'b1, 4'b0010, 1'b1);
    q[0].push_back(16'hA0FF);
    refresh();
    step(); expect_out("pkt.f1", 4'b0010, 16'h0055, 1'b1, 4'b0010, 1'b1);
    step(); expect_out("pkt.f2", 4'b0010, 16'h8077, 1'b1, 4'b0010, 1'b0);
    step(); expect_out("pkt.p0", 4'b0001, 16'hA0FF, 1'b1, 4'b0001, 1'b0);
    step();

    // backpressure while locked
    q[2].push_back(16'h2011);
    q[2].push_back(16'h0022);
    q[2].push_back(16'h0033);
    q[2].push_back(16'h8044);
    refresh();
    step(); expect_out("bp.hdr", 4'b0100, 16'h2011, 1'b1, 4'b0100, 1'b1);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); expect_out($sformatf("bp.stall%0d", k), 4'b0000, 16'h2011, 1'b1, 4'b0100, 1'b1);
    end
    bus.out_ready = 1'b1;
    step(); expect_out("bp.b1",   4'b0100, 16'h0022, 1'b1, 4'b0100, 1'b1);
    step(); expect_out("bp.b2",   4'b0100, 16'h0033, 1'b1, 4'b0100, 1'b1);
    step(); expect_out("bp.last", 4'b0100, 16'h8044, 1'b1, 4'b0100, 1'b0);
    step(); expect_out("bp.idle", 4'b0000, 16'h8044, 1'b0, 4'b0000, 1'b0);

    // owner FIFO runs dry mid-packet
    q[2].push_back(16'h2000);
    refresh();
    step(); expect_out("dry.hdr", 4'b0100, 16'h2000, 1'b1, 4'b0100, 1'b1);
    q[0].push_back(16'hA0AA);
    refresh();
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("dry.rd%0d", k),    bus.rd_o, 4'b0000);
      check($sformatf("dry.busy%0d", k),  busy,     1'b1);
      check($sformatf("dry.grant%0d", k), grant_o,  4'b0100);
    end
    q[2].push_back(16'h8055);
    refresh();
    step(); expect_out("dry.body", 4'b0100, 16'h8055, 1'b1, 4'b0100, 1'b0);
    step(); expect_out("dry.p0",   4'b0001, 16'hA0AA, 1'b1, 4'b0001, 1'b0);
    step();

    // reset in the middle of a packet
    q[1].push_back(16'h2101);
    q[1].push_back(16'h0102);
    q[1].push_back(16'h8103);
    refresh();
    step(); check("rst.f0", bus.out_data, 16'h2101);
    step(); check("rst.f1", bus.out_data, 16'h0102);
    reset = 1'b1;
    #1;
    expect_out("rst.now", 4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0);
    step();
    check("rst.rd_held", bus.rd_o, 4'b0000);
    check("rst.no_pop", q[1].size(), 1);
    reset = 1'b0;
    q[0].push_back(16'hA0D0);
    q[3].push_back(16'hA0D3);
    refresh();
    step(); expect_out("rst.p0", 4'b0001, 16'hA0D0, 1'b1, 4'b0001, 1'b0);
    step(); expect_out("rst.p3", 4'b1000, 16'hA0D3, 1'b1, 4'b1000, 1'b0);
    step();
    check("rst.abandoned", q[1].size(), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
